// File: rtl/bnn_conv3x3_stream.sv
// Streaming 3x3 binary (XNOR-popcount-threshold) convolution over a raster 1-bit pixel stream.
// Optional popcount output port is enabled by defining BNN_CONV_POPCNT_OUT_EN.
module bnn_conv3x3_stream #(
    parameter int                   WIDTH   = 28,
    parameter int                   HEIGHT  = 28,
    parameter int                   CH_OUT  = 8,
    parameter int                   STRIDE  = 1,
    parameter logic [CH_OUT*9-1:0]  WEIGHTS = {CH_OUT*9{1'b1}},
    parameter logic [CH_OUT*4-1:0]  THRESH  = {CH_OUT{4'd5}}
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                valid_in,
    input  logic                sof,
    input  logic                pixel_in,
    output logic [CH_OUT-1:0]   conv_out,
    output logic                valid_out,
`ifdef BNN_CONV_POPCNT_OUT_EN
    output logic [CH_OUT*4-1:0] popcnt_out,
`endif
    output logic                frame_done
);

    localparam int CW           = $clog2(WIDTH);
    localparam int RW           = $clog2(HEIGHT);
    localparam int LAST_WIN_ROW = 2 + STRIDE * ((HEIGHT - 3) / STRIDE);
    localparam int LAST_WIN_COL = 2 + STRIDE * ((WIDTH - 3) / STRIDE);

    localparam logic [RW-1:0] ROW_LAST     = RW'(HEIGHT - 1);
    localparam logic [CW-1:0] COL_LAST     = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_WIN_LAST = RW'(LAST_WIN_ROW);
    localparam logic [CW-1:0] COL_WIN_LAST = CW'(LAST_WIN_COL);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [RW-1:0]       row_r;
    logic [CW-1:0]       col_r;
    logic [RW-1:0]       row_next_s;
    logic [CW-1:0]       col_next_s;
    logic [RW-1:0]       cur_row_s;
    logic [CW-1:0]       cur_col_s;
    logic                accept_s;
    logic                last_px_s;
    logic                win_ok_s;
    logic                last_win_s;

    logic [WIDTH-1:0]    lb0_r;
    logic [WIDTH-1:0]    lb1_r;
    logic [2:0]          col_m1_r;
    logic [2:0]          col_m2_r;
    logic [2:0]          cur_px_s;
    logic [8:0]          win_s;
    logic [3:0]          cnt_s [CH_OUT];
    logic [CH_OUT-1:0]   bit_s;

    function automatic logic [3:0] popcnt9(input logic [8:0] v);
        logic [3:0] s;
        s = 4'd0;
        for (int i = 0; i < 9; i++) begin
            s = s + {3'b000, v[i]};
        end
        return s;
    endfunction

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (valid_in && sof) begin
                    state_s = ACTIVE;
                end else begin
                    state_s = IDLE;
                end
            end
            ACTIVE: begin
                if (accept_s && last_px_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = ACTIVE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // FSM outputs: pixel acceptance, its position, window gating and counter update
    always_comb begin
        accept_s = valid_in && (sof || (state_r == ACTIVE));
        if (sof) begin
            cur_row_s = {RW{1'b0}};
            cur_col_s = {CW{1'b0}};
        end else begin
            cur_row_s = row_r;
            cur_col_s = col_r;
        end
        last_px_s = (cur_row_s == ROW_LAST) && (cur_col_s == COL_LAST);
        // Stride-2 alignment: (r-2) even is the same as r even.
        win_ok_s  = accept_s && (cur_row_s >= RW'(2)) && (cur_col_s >= CW'(2)) &&
                    ((STRIDE == 1) || (!cur_row_s[0] && !cur_col_s[0]));
        last_win_s = win_ok_s && (cur_row_s == ROW_WIN_LAST) && (cur_col_s == COL_WIN_LAST);
        if (!accept_s) begin
            row_next_s = row_r;
            col_next_s = col_r;
        end else if (last_px_s) begin
            row_next_s = {RW{1'b0}};
            col_next_s = {CW{1'b0}};
        end else if (cur_col_s == COL_LAST) begin
            row_next_s = cur_row_s + RW'(1);
            col_next_s = {CW{1'b0}};
        end else begin
            row_next_s = cur_row_s;
            col_next_s = cur_col_s + CW'(1);
        end
    end

    // Position of the next expected pixel
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_r <= {RW{1'b0}};
            col_r <= {CW{1'b0}};
        end else begin
            row_r <= row_next_s;
            col_r <= col_next_s;
        end
    end

    // Line buffers and the two stored window columns; frozen while no pixel is accepted
    always_ff @(posedge clk) begin
        if (accept_s) begin
            lb0_r    <= {lb0_r[WIDTH-2:0], pixel_in};
            lb1_r    <= {lb1_r[WIDTH-2:0], lb0_r[WIDTH-1]};
            col_m2_r <= col_m1_r;
            col_m1_r <= cur_px_s;
        end
    end

    // Window assembly: index 0 of each column is row r-2, index 2 is row r
    always_comb begin
        cur_px_s = {pixel_in, lb0_r[WIDTH-1], lb1_r[WIDTH-1]};
        win_s    = 9'd0;
        for (int j = 0; j < 3; j++) begin
            win_s[j*3 + 0] = col_m2_r[j];
            win_s[j*3 + 1] = col_m1_r[j];
            win_s[j*3 + 2] = cur_px_s[j];
        end
    end

    // Per-channel XNOR popcount and threshold compare
    always_comb begin
        for (int c = 0; c < CH_OUT; c++) begin
            cnt_s[c] = popcnt9(~(win_s ^ WEIGHTS[c*9 +: 9]));
            bit_s[c] = (cnt_s[c] >= THRESH[c*4 +: 4]);
        end
    end

    // Registered outputs; conv_out holds between windows
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            conv_out   <= {CH_OUT{1'b0}};
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            valid_out  <= win_ok_s;
            frame_done <= last_win_s;
            if (win_ok_s) begin
                conv_out <= bit_s;
            end else begin
                conv_out <= conv_out;
            end
        end
    end

`ifdef BNN_CONV_POPCNT_OUT_EN
    logic [CH_OUT*4-1:0] cnt_flat_s;

    // Flatten channel counts for the popcount port
    always_comb begin
        cnt_flat_s = {CH_OUT*4{1'b0}};
        for (int c = 0; c < CH_OUT; c++) begin
            cnt_flat_s[c*4 +: 4] = cnt_s[c];
        end
    end

    // Popcount register, same timing as conv_out
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            popcnt_out <= {CH_OUT*4{1'b0}};
        end else if (win_ok_s) begin
            popcnt_out <= cnt_flat_s;
        end else begin
            popcnt_out <= popcnt_out;
        end
    end
`endif

endmodule

// File: tb/tb_bnn_conv3x3_stream.sv
// Bench: stride-1 and stride-2 instances on a shared stream, checked every cycle against
// a frame-array reference model, plus table-driven per-frame totals and directed corner cases.
module tb_bnn_conv3x3_stream;

    localparam int W  = 28;
    localparam int H  = 28;
    localparam int CH = 8;
    localparam logic [CH*9-1:0] WTS = {9'b000111000, 9'b111000111, 9'b011100110, 9'b110011001,
                                       9'b101010101, 9'b000000000, 9'b111111111, 9'b000010000};
    localparam logic [CH*4-1:0] THR = {4'd7, 4'd3, 4'd10, 4'd0, 4'd5, 4'd9, 4'd9, 4'd9};

    logic clk, rst_n, valid_in, sof, pixel_in;
    logic [CH-1:0] conv1, conv2;
    logic vo1, vo2, fd1, fd2;
`ifdef BNN_CONV_POPCNT_OUT_EN
    logic [CH*4-1:0] pc1, pc2;
`endif

    bnn_conv3x3_stream #(.WIDTH(W), .HEIGHT(H), .CH_OUT(CH), .STRIDE(1), .WEIGHTS(WTS), .THRESH(THR)) dut1 (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .sof(sof), .pixel_in(pixel_in),
        .conv_out(conv1), .valid_out(vo1),
`ifdef BNN_CONV_POPCNT_OUT_EN
        .popcnt_out(pc1),
`endif
        .frame_done(fd1));

    bnn_conv3x3_stream #(.WIDTH(W), .HEIGHT(H), .CH_OUT(CH), .STRIDE(2), .WEIGHTS(WTS), .THRESH(THR)) dut2 (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .sof(sof), .pixel_in(pixel_in),
        .conv_out(conv2), .valid_out(vo2),
`ifdef BNN_CONV_POPCNT_OUT_EN
        .popcnt_out(pc2),
`endif
        .frame_done(fd2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // reference model state
    bit              m_active;
    int              m_r, m_c;
    bit              img [H][W];
    bit              rnd_img [H][W];
    logic            e_vo [2];
    logic            e_fd [2];
    logic [CH-1:0]   e_conv [2];
    logic [CH*4-1:0] e_pc [2];

    // per-frame statistics taken from DUT outputs
    int pulses [2], dones [2], done_at [2], ch0n [2], ch21_bad [2];
    logic [1:0] cur_ch21;

    typedef struct {
        int         mode;      // 0 zeros, 1 ones, 2 single pixel at (5,5), 3 stored random frame
        int         gap;       // percent chance of an idle cycle before each pixel
        int         n1;        // outputs per frame, stride 1
        int         n2;        // outputs per frame, stride 2
        int         ch0_ones;  // expected ch0=1 outputs per frame, -1 = unchecked
        bit         chk21;
        logic [1:0] ch21;      // expected {ch2,ch1} on every output
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit complete(input int r, input int c, input int st);
        return (r >= 2) && (c >= 2) && ((st == 1) || (((r - 2) % 2 == 0) && ((c - 2) % 2 == 0)));
    endfunction

    task automatic window_eval(input int r, input int c, output logic [CH-1:0] bits,
                               output logic [CH*4-1:0] pcs);
        logic [CH*9-1:0] wv;
        logic [CH*4-1:0] tv;
        int cnt;
        wv = WTS;
        tv = THR;
        bits = '0;
        pcs = '0;
        for (int ch = 0; ch < CH; ch++) begin
            cnt = 0;
            for (int k = 0; k < 9; k++)
                if (img[r - 2 + k / 3][c - 2 + k % 3] == wv[ch*9 + k]) cnt++;
            bits[ch] = (cnt >= int'(tv[ch*4 +: 4]));
            pcs[ch*4 +: 4] = 4'(cnt);
        end
    endtask

    task automatic model(input bit rn, input bit v, input bit s, input bit p);
        int r, c, st, lw_r, lw_c;
        if (!rn) begin
            m_active = 1'b0; m_r = 0; m_c = 0;
            for (int d = 0; d < 2; d++) begin
                e_vo[d] = 1'b0; e_fd[d] = 1'b0; e_conv[d] = '0; e_pc[d] = '0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                e_vo[d] = 1'b0; e_fd[d] = 1'b0;
            end
            if (v && (m_active || s)) begin
                if (s) begin r = 0; c = 0; end
                else begin r = m_r; c = m_c; end
                img[r][c] = p;
                for (int d = 0; d < 2; d++) begin
                    st = d + 1;
                    lw_r = 2 + st * ((H - 3) / st);
                    lw_c = 2 + st * ((W - 3) / st);
                    if (complete(r, c, st)) begin
                        e_vo[d] = 1'b1;
                        e_fd[d] = (r == lw_r) && (c == lw_c);
                        window_eval(r, c, e_conv[d], e_pc[d]);
                    end
                end
                if (r == H - 1 && c == W - 1) begin
                    m_active = 1'b0; m_r = 0; m_c = 0;
                end else begin
                    m_active = 1'b1;
                    if (c == W - 1) begin m_c = 0; m_r = r + 1; end
                    else begin m_c = c + 1; m_r = r; end
                end
            end
        end
    endtask

    task automatic check_outputs();
        chk("valid_out_s1", vo1, e_vo[0]);
        chk("frame_done_s1", fd1, e_fd[0]);
        chk("conv_out_s1", conv1, e_conv[0]);
        chk("valid_out_s2", vo2, e_vo[1]);
        chk("frame_done_s2", fd2, e_fd[1]);
        chk("conv_out_s2", conv2, e_conv[1]);
`ifdef BNN_CONV_POPCNT_OUT_EN
        chk("popcnt_s1", pc1, e_pc[0]);
        chk("popcnt_s2", pc2, e_pc[1]);
`endif
        if (vo1) begin
            pulses[0]++;
            if (conv1[0]) ch0n[0]++;
            if (conv1[2:1] != cur_ch21) ch21_bad[0]++;
        end
        if (fd1) begin dones[0]++; done_at[0] = pulses[0]; end
        if (vo2) begin
            pulses[1]++;
            if (conv2[0]) ch0n[1]++;
            if (conv2[2:1] != cur_ch21) ch21_bad[1]++;
        end
        if (fd2) begin dones[1]++; done_at[1] = pulses[1]; end
    endtask

    task automatic step(input bit rn, input bit v, input bit s, input bit p);
        rst_n = rn; valid_in = v; sof = s; pixel_in = p;
        model(rn, v, s, p);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic clear_stats();
        for (int d = 0; d < 2; d++) begin
            pulses[d] = 0; dones[d] = 0; done_at[d] = 0; ch0n[d] = 0; ch21_bad[d] = 0;
        end
    endtask

    function automatic bit pix_of(input int mode, input int r, input int c);
        case (mode)
            0: return 1'b0;
            1: return 1'b1;
            2: return (r == 5 && c == 5);
            default: return rnd_img[r][c];
        endcase
    endfunction

    // send the first n pixels of a frame in raster order, with random idle gaps
    task automatic send_pixels(input int mode, input int gap, input int n);
        int k;
        k = 0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                if (k < n) begin
                    while (gap > 0 && int'($urandom_range(99)) < gap)
                        step(1'b1, 1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)));
                    step(1'b1, 1'b1, (r == 0 && c == 0), pix_of(mode, r, c));
                end
                k++;
            end
    endtask

    initial begin
        rst_n = 1'b0; valid_in = 1'b0; sof = 1'b0; pixel_in = 1'b0;
        cur_ch21 = 2'b00;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) rnd_img[r][c] = 1'($urandom_range(1));

        tbl[0] = '{mode: 1, gap: 0,  n1: 676, n2: 169, ch0_ones: 0,  chk21: 1'b1, ch21: 2'b01};
        tbl[1] = '{mode: 0, gap: 0,  n1: 676, n2: 169, ch0_ones: 0,  chk21: 1'b1, ch21: 2'b10};
        tbl[2] = '{mode: 2, gap: 0,  n1: 676, n2: 169, ch0_ones: 1,  chk21: 1'b0, ch21: 2'b00};
        tbl[3] = '{mode: 3, gap: 0,  n1: 676, n2: 169, ch0_ones: -1, chk21: 1'b0, ch21: 2'b00};
        tbl[4] = '{mode: 3, gap: 40, n1: 676, n2: 169, ch0_ones: -1, chk21: 1'b0, ch21: 2'b00};
        tbl[5] = '{mode: 1, gap: 40, n1: 676, n2: 169, ch0_ones: 0,  chk21: 1'b1, ch21: 2'b01};

        // reset state
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset_conv", conv1, 8'h00);
        chk("reset_valid", vo1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1);   // valid without sof while idle
        chk("idle_no_sof", vo1, 1'b0);

        // table-driven full frames
        for (int i = 0; i < 6; i++) begin
            clear_stats();
            cur_ch21 = tbl[i].ch21;
            send_pixels(tbl[i].mode, tbl[i].gap, W * H);
            step(1'b1, 1'b0, 1'b0, 1'b0);
            step(1'b1, 1'b0, 1'b0, 1'b0);
            chk("n_out_s1", pulses[0], tbl[i].n1);
            chk("n_out_s2", pulses[1], tbl[i].n2);
            chk("n_done_s1", dones[0], 1);
            chk("n_done_s2", dones[1], 1);
            chk("done_at_s1", done_at[0], tbl[i].n1);
            chk("done_at_s2", done_at[1], tbl[i].n2);
            if (tbl[i].ch0_ones >= 0) begin
                chk("ch0_ones_s1", ch0n[0], tbl[i].ch0_ones);
                chk("ch0_ones_s2", ch0n[1], tbl[i].ch0_ones);
            end
            if (tbl[i].chk21) begin
                chk("ch21_s1", ch21_bad[0], 0);
                chk("ch21_s2", ch21_bad[1], 0);
            end
        end

        // resync: sof arrives on the pixel that would be (10,3)
        clear_stats();
        send_pixels(3, 0, 10 * W + 3);
        chk("partial_done_s1", dones[0], 0);
        chk("partial_done_s2", dones[1], 0);
        clear_stats();
        send_pixels(1, 0, W * H);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("resync_n_s1", pulses[0], 676);
        chk("resync_n_s2", pulses[1], 169);
        chk("resync_done_s1", dones[0], 1);
        chk("resync_done_s2", dones[1], 1);
        clear_stats();
        for (int i = 0; i < 60; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("after_frame_s1", pulses[0], 0);
        chk("after_frame_s2", pulses[1], 0);

        // reset in the middle of a frame
        send_pixels(3, 10, 300);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        chk("midrst_conv_s1", conv1, 8'h00);
        chk("midrst_conv_s2", conv2, 8'h00);
        chk("midrst_valid_s1", vo1, 1'b0);
        clear_stats();
        for (int i = 0; i < 100; i++) step(1'b1, 1'b1, 1'b0, 1'($urandom_range(1)));
        chk("postrst_n_s1", pulses[0], 0);
        chk("postrst_n_s2", pulses[1], 0);
        clear_stats();
        send_pixels(3, 20, W * H);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("refill_n_s1", pulses[0], 676);
        chk("refill_n_s2", pulses[1], 169);
        chk("refill_done_s1", dones[0], 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
